mlp_window_collector: RTL

//  Consumer end of the 7x7 neighbourhood read: accepts two time-surface words per beat from the

---
 rtl/mlp_window_collector.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/mlp_window_collector.sv
// Collects the 49 time-surface words of a 7x7 event neighbourhood and packs them into an activation vector.
// Optional feature: define CENTER_SELF_MASK_EN to force the event pixel's own activation (index 24) to 0.
module mlp_window_collector #(
  parameter int unsigned CAVIAR_X_Y_BITS = 9,
  parameter int unsigned X_MAX           = 127,
  parameter int unsigned Y_MAX           = 127,
  parameter int unsigned TS_BITS         = 16,
  parameter int unsigned TAU_LOG2        = 10,
  parameter int unsigned ACT_BITS        = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start,
  input  logic [CAVIAR_X_Y_BITS-1:0] ev_x,
  input  logic [CAVIAR_X_Y_BITS-1:0] ev_y,
  input  logic [TS_BITS-1:0]         ev_t,
  input  logic                       rd_valid,
  input  logic [TS_BITS-1:0]         rd_data1,
  input  logic [TS_BITS-1:0]         rd_data2,
  output logic                       busy,
  output logic                       start_drop,
  output logic                       act_valid,
  input  logic                       act_ready,
  output logic [49*ACT_BITS-1:0]     act_vec
);

  localparam int unsigned CW        = CAVIAR_X_Y_BITS + 1;
  localparam int unsigned NPIX      = 49;
  localparam int unsigned VEC_W     = NPIX * ACT_BITS;
  localparam int unsigned LAST_BEAT = 24;
  localparam int unsigned CENTER    = 24;
  localparam int unsigned SHIFT     = TAU_LOG2 - ACT_BITS;
  localparam logic [TS_BITS-1:0] WINDOW = TS_BITS'(2 ** TAU_LOG2);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    OUT     = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [4:0]                 beat_q, beat_d;
  logic [2:0]                 row_q, row_d;
  logic [2:0]                 col_q, col_d;
  logic [CAVIAR_X_Y_BITS-1:0] ev_x_q, ev_x_d;
  logic [CAVIAR_X_Y_BITS-1:0] ev_y_q, ev_y_d;
  logic [TS_BITS-1:0]         ev_t_q, ev_t_d;
  logic [VEC_W-1:0]           act_vec_q, act_vec_d;
  logic                       busy_q, busy_d;
  logic                       start_drop_q, start_drop_d;
  logic                       act_valid_q, act_valid_d;

  logic [2:0]                 row1_c, col1_c;
  int unsigned                idx0_c, idx1_c;
  logic [ACT_BITS-1:0]        act0_c, act1_c;

  // Window coordinate base + off - 3, evaluated signed one bit wider than the coordinate
  function automatic logic coord_oob(input logic [CAVIAR_X_Y_BITS-1:0] base,
                                     input logic [2:0] off,
                                     input int unsigned lim);
    logic signed [CW-1:0] p;
    p = $signed({1'b0, base}) + $signed(CW'(off)) - $signed(CW'(3));
    return (p < $signed(CW'(0))) || (p > $signed(CW'(lim)));
  endfunction

  // Linear decay of age within the window, quantised to ACT_BITS
  function automatic logic [ACT_BITS-1:0] ts_to_act(input logic [TS_BITS-1:0] et,
                                                    input logic [TS_BITS-1:0] ts);
    logic [TS_BITS-1:0] delta;
    logic [TS_BITS-1:0] rem;
    delta = et - ts;
    if (delta >= WINDOW) begin
      return '0;
    end
    rem = WINDOW - TS_BITS'(1) - delta;
    return ACT_BITS'(rem >> SHIFT);
  endfunction

  function automatic logic [ACT_BITS-1:0] pixel_act(input logic [TS_BITS-1:0] ts,
                                                    input logic [2:0] row,
                                                    input logic [2:0] col,
                                                    input int unsigned idx);
    logic [ACT_BITS-1:0] a;
    if (coord_oob(ev_x_q, col, X_MAX) || coord_oob(ev_y_q, row, Y_MAX)) begin
      a = '0;
    end else begin
      a = ts_to_act(ev_t_q, ts);
    end
`ifdef CENTER_SELF_MASK_EN
    if (idx == CENTER) begin
      a = '0;
    end
`else
    if (idx == NPIX) begin
      a = '0;
    end
`endif
    return a;
  endfunction

  // Position of the odd pixel of the current beat, one step after (row_q, col_q)
  always_comb begin
    row1_c = row_q;
    col1_c = col_q + 3'd1;
    if (col_q == 3'd6) begin
      row1_c = row_q + 3'd1;
      col1_c = 3'd0;
    end
    idx0_c = 32'(row_q) * 7 + 32'(col_q);
    idx1_c = 32'(row1_c) * 7 + 32'(col1_c);
    act0_c = pixel_act(rd_data1, row_q, col_q, idx0_c);
    act1_c = pixel_act(rd_data2, row1_c, col1_c, idx1_c);
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    row_d        = row_q;
    col_d        = col_q;
    ev_x_d       = ev_x_q;
    ev_y_d       = ev_y_q;
    ev_t_d       = ev_t_q;
    act_vec_d    = act_vec_q;
    start_drop_d = start && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = COLLECT;
          ev_x_d    = ev_x;
          ev_y_d    = ev_y;
          ev_t_d    = ev_t;
          beat_d    = '0;
          row_d     = '0;
          col_d     = '0;
          act_vec_d = '0;
        end
      end
      COLLECT: begin
        if (rd_valid) begin
          for (int unsigned i = 0; i < NPIX; i++) begin
            if (i == idx0_c) begin
              act_vec_d[i*ACT_BITS +: ACT_BITS] = act0_c;
            end
            if ((i == idx1_c) && (32'(beat_q) != LAST_BEAT)) begin
              act_vec_d[i*ACT_BITS +: ACT_BITS] = act1_c;
            end
          end
          beat_d = beat_q + 5'd1;
          // Even pixel advances two window positions per beat
          if (col_q >= 3'd5) begin
            col_d = col_q - 3'd5;
            row_d = row_q + 3'd1;
          end else begin
            col_d = col_q + 3'd2;
          end
          if (32'(beat_q) == LAST_BEAT) begin
            state_d = OUT;
          end
        end
      end
      OUT: begin
        if (act_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    act_valid_d = (state_d == OUT);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      row_q        <= '0;
      col_q        <= '0;
      ev_x_q       <= '0;
      ev_y_q       <= '0;
      ev_t_q       <= '0;
      act_vec_q    <= '0;
      busy_q       <= 1'b0;
      start_drop_q <= 1'b0;
      act_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      row_q        <= row_d;
      col_q        <= col_d;
      ev_x_q       <= ev_x_d;
      ev_y_q       <= ev_y_d;
      ev_t_q       <= ev_t_d;
      act_vec_q    <= act_vec_d;
      busy_q       <= busy_d;
      start_drop_q <= start_drop_d;
      act_valid_q  <= act_valid_d;
    end
  end

  assign busy       = busy_q;
  assign start_drop = start_drop_q;
  assign act_valid  = act_valid_q;
  assign act_vec    = act_vec_q;

endmodule
